grad_des_multistart_ctrl: RTL
=============================

Name: grad_des_multistart_ctrl

Overview:
Multi-start scheduler for the 4D gradient-descent core. It holds a table of up to NUM_STARTS integer seed points (a, b, c, d) written by the host, and launches the core once per seed. Each launch uses the core's start_op/done_op level handshake. The block keeps the lowest z_min returned and its final a/b/c/d, which lets a single core search several basins. It sits between the host/CSR logic and one gradient-descent core instance.

Parameters:
NUM_STARTS, 8, seed table depth (>=1)
EARLY_EXIT_Z, 32'h0000_0000, signed Q24.8 threshold used only when GD_MS_EARLY_EXIT_EN is defined

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seed_wr_en  input  1  write strobe for seed table
seed_wr_addr  input  $clog2(NUM_STARTS)  seed slot
seed_wr_data  input  32  {a[31:24], b[23:16], c[15:8], d[7:0]}, each signed 8-bit integer
run_count  input  $clog2(NUM_STARTS+1)  number of seeds to run, latched on start
start  input  1  single-cycle run request
busy  output  1  run in progress
done  output  1  result valid; held until next accepted start
best_z  output  32  signed Q24.8 lowest z_min seen
best_a, best_b, best_c, best_d  output  8 each  signed final point of best run
best_idx  output  $clog2(NUM_STARTS)  seed slot that produced best_z
core_start_op  output  1  to core start_op
core_a_init, core_b_init, core_c_init, core_d_init  output  8 each  to core initial inputs
core_z_min  input  32  from core z_min
core_final_a, core_final_b, core_final_c, core_final_d  input  8 each  from core final_*_at_min
core_done_op  input  1  from core done_op

Behaviour:
- Reset values (asynchronous): all outputs 0 except best_z = 32'h7FFF_FFFF; state IDLE; seed table all 0; idx 0.
- Seed writes are accepted only in IDLE (busy=0) and ignored while busy. A write in the same cycle as an accepted start is ignored.
- States are IDLE, LAUNCH, WAIT_DONE, CAPTURE, RELEASE, FINISH.
- IDLE: start=1 latches run_count into cnt, clears done, sets idx=0, best_z=7FFF_FFFF, best_* =0, best_idx=0.
  - If cnt==0 -> FINISH. Otherwise -> LAUNCH and busy=1.
  - start is ignored in every other state.
- LAUNCH: core_*_init are registered from seed[idx] and core_start_op<=1 in the same edge; -> WAIT_DONE.
  - core_*_init hold stable until the next LAUNCH.
- WAIT_DONE: core_start_op held 1; core_done_op=1 -> CAPTURE. There is no timeout.
- CAPTURE:
  - If core_z_min < best_z (signed, strict) -> best_z, best_a..d, best_idx update from core outputs and idx. Ties keep the earlier slot.
  - core_start_op<=0; -> RELEASE.
- RELEASE: waits until core_done_op==0, which guarantees the core is back in IDLE. Then:
  - if idx==cnt-1 -> FINISH;
  - else idx<=idx+1 -> LAUNCH.
- FINISH: busy<=0, done<=1; -> IDLE. done stays 1 until the next accepted start.
- run_count > NUM_STARTS is clamped to NUM_STARTS.
- Minimum per-seed overhead is 3 controller cycles plus core latency plus the done_op fall.
- Reset mid-run: returns to IDLE immediately, all outputs go to reset values, and the seed table is cleared.
  - The core is reset by the same rst_n, so there are no stale handshakes.

Optional Feature:
GD_MS_EARLY_EXIT_EN:
- Defined: in CAPTURE, after the best-update, if the updated best_z <= EARLY_EXIT_Z (signed), RELEASE proceeds to FINISH regardless of idx. An extra output early_exit (1 bit, reset 0, cleared on start) is set to 1.
- Undefined: all cnt seeds always run, the port is absent, and EARLY_EXIT_Z is unused.

Test Plan:
1. Bench drives a stub core: 5-cycle latency, z = 256*(|a|+|b|+|c|+|d|), finals = inits. Seeds {3,-2,1,0}, {0,0,1,0}, {5,5,5,5}, run_count=3, start -> done after 3 launches; best_z=32'h0000_0100, best_a..d=0,0,1,0, best_idx=1.
2. Tie: slots 0 and 1 both {1,0,0,0}, run_count=2 -> best_idx=0, best_z=32'h0000_0100.
3. run_count=0, start -> busy never rises; done=1 two cycles after start; best_z=32'h7FFF_FFFF; core_start_op stays 0.
4. Handshake: stub holds done_op high 4 extra cycles after start_op falls -> next core_start_op rise only after done_op==0; never two start rises inside one done_op high window.
5. start pulse and seed write while busy -> both ignored; the result matches an undisturbed run. rst_n low during WAIT_DONE -> best_z=7FFF_FFFF, busy=0, done=0, core_start_op=0.
6. With GD_MS_EARLY_EXIT_EN, EARLY_EXIT_Z=0: seeds {2,2,2,2}, {0,0,0,0}, {1,1,1,1}, run_count=3 -> only 2 launches; early_exit=1; best_idx=1; best_z=0.

Source files
------------

// File: rtl/grad_des_multistart_ctrl.sv
// Multi-start scheduler: launches one gradient-descent core once per host-written seed
// and keeps the lowest z_min with its final point. Optional early exit: GD_MS_EARLY_EXIT_EN.
module grad_des_multistart_ctrl #(
  parameter int                 NUM_STARTS   = 8,
  parameter logic signed [31:0] EARLY_EXIT_Z = 32'sh0000_0000,
  localparam int IW = (NUM_STARTS > 1) ? $clog2(NUM_STARTS) : 1,
  localparam int CW = $clog2(NUM_STARTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seed_wr_en,
  input  logic [IW-1:0] seed_wr_addr,
  input  logic [31:0]   seed_wr_data,
  input  logic [CW-1:0] run_count,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [31:0]   best_z,
  output logic [7:0]    best_a,
  output logic [7:0]    best_b,
  output logic [7:0]    best_c,
  output logic [7:0]    best_d,
  output logic [IW-1:0] best_idx,
  output logic          core_start_op,
  output logic [7:0]    core_a_init,
  output logic [7:0]    core_b_init,
  output logic [7:0]    core_c_init,
  output logic [7:0]    core_d_init,
  input  logic [31:0]   core_z_min,
  input  logic [7:0]    core_final_a,
  input  logic [7:0]    core_final_b,
  input  logic [7:0]    core_final_c,
  input  logic [7:0]    core_final_d,
  input  logic          core_done_op
`ifdef GD_MS_EARLY_EXIT_EN
  ,
  output logic          early_exit
`endif
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_DONE, CAPTURE, RELEASE, FINISH
  } state_t;

  state_t        state_reg;
  logic [31:0]   seed_mem [NUM_STARTS];
  logic [IW-1:0] idx_reg;
  logic [CW-1:0] cnt_reg;

  logic          seed_wr_ok;
  logic [CW-1:0] run_clamped;
  logic          last_seed;
  logic          z_better;
  logic [31:0]   upd_z;
  logic          stop_early;

  // A write colliding with an accepted start is dropped so the run sees a stable table.
  assign seed_wr_ok  = (state_reg == IDLE) && seed_wr_en && !start;
  assign run_clamped = (run_count > CW'(NUM_STARTS)) ? CW'(NUM_STARTS) : run_count;
  assign last_seed   = ((CW+1)'(idx_reg) + (CW+1)'(1)) == {1'b0, cnt_reg};
  assign z_better    = $signed(core_z_min) < $signed(best_z);
  assign upd_z       = z_better ? core_z_min : best_z;

`ifdef GD_MS_EARLY_EXIT_EN
  assign stop_early = early_exit;
`else
  logic [31:0] unused_early_z;
  assign unused_early_z = EARLY_EXIT_Z;
  assign stop_early     = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_STARTS; gi++) begin : g_seed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seed_mem[gi] <= '0;
        end else if (seed_wr_ok && (int'(seed_wr_addr) == gi)) begin
          seed_mem[gi] <= seed_wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      best_z        <= 32'h7FFF_FFFF;
      best_a        <= '0;
      best_b        <= '0;
      best_c        <= '0;
      best_d        <= '0;
      best_idx      <= '0;
      core_start_op <= 1'b0;
      core_a_init   <= '0;
      core_b_init   <= '0;
      core_c_init   <= '0;
      core_d_init   <= '0;
`ifdef GD_MS_EARLY_EXIT_EN
      early_exit    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg  <= run_clamped;
            done     <= 1'b0;
            idx_reg  <= '0;
            best_z   <= 32'h7FFF_FFFF;
            best_a   <= '0;
            best_b   <= '0;
            best_c   <= '0;
            best_d   <= '0;
            best_idx <= '0;
`ifdef GD_MS_EARLY_EXIT_EN
            early_exit <= 1'b0;
`endif
            if (run_clamped == '0) begin
              state_reg <= FINISH;
            end else begin
              busy      <= 1'b1;
              state_reg <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          core_a_init   <= seed_mem[idx_reg][31:24];
          core_b_init   <= seed_mem[idx_reg][23:16];
          core_c_init   <= seed_mem[idx_reg][15:8];
          core_d_init   <= seed_mem[idx_reg][7:0];
          core_start_op <= 1'b1;
          state_reg     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_done_op) state_reg <= CAPTURE;
        end
        CAPTURE: begin
          // Strict compare: on a tie the earlier slot stays the winner.
          if (z_better) begin
            best_z   <= core_z_min;
            best_a   <= core_final_a;
            best_b   <= core_final_b;
            best_c   <= core_final_c;
            best_d   <= core_final_d;
            best_idx <= idx_reg;
          end
`ifdef GD_MS_EARLY_EXIT_EN
          if ($signed(upd_z) <= EARLY_EXIT_Z) early_exit <= 1'b1;
`endif
          core_start_op <= 1'b0;
          state_reg     <= RELEASE;
        end
        RELEASE: begin
          // done_op low means the core has returned to idle and can take a new start.
          if (!core_done_op) begin
            if (last_seed || stop_early) begin
              state_reg <= FINISH;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= LAUNCH;
            end
          end
        end
        FINISH: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
